rf_write_ctrl: RTL and testbench

RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

---
 rtl/rf_ctrl_pkg.sv | 15 +
 rtl/rf_write_ctrl_if.sv | 26 ++
 rtl/rf_write_ctrl_rr_arbiter.sv | 48 ++++
 rtl/rf_write_ctrl.sv | 136 +++++++++++++
 tb/tb_rf_write_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and sizes for the register-file write-back controller.
package rf_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_ctrl_if.sv
// Write-back request bundle: one valid/ready handshake plus destination and value per requester.
interface rf_write_ctrl_if #(
  parameter int N_REQ = 2,
  parameter int DW    = 32
);

  logic [N_REQ-1:0]                         req_valid;
  logic [N_REQ-1:0]                         req_ready;
  rf_ctrl_pkg::reg_addr_t [N_REQ-1:0]       req_addr;
  logic [N_REQ-1:0][DW-1:0]                 req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rf_write_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, the most recently granted requester has lowest priority.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_reg;
  logic [IW-1:0] last_next;
  logic          found;

  // Two passes: requesters above the last winner first, then wrap around.
  always_comb begin
    gnt       = '0;
    last_next = last_reg;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(last_reg))) begin
        gnt[i]    = 1'b1;
        last_next = IW'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i <= int'(last_reg))) begin
        gnt[i]    = 1'b1;
        last_next = IW'(i);
        found     = 1'b1;
      end
    end
  end

  // Resetting to the highest index makes requester 0 the first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= IW'(N - 1);
    end else if (en) begin
      last_reg <= last_next;
    end
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write-back controller: per-requester hold buffers, round-robin write port, pending-write scoreboard.
module rf_write_ctrl #(
  parameter int N_REQ = 2,
  parameter int XLEN  = rf_ctrl_pkg::XLEN
) (
  input  logic                                clk,
  input  logic                                rst_n,
  rf_write_ctrl_if.slave                      wb,
  input  logic                                rsv_valid,
  input  rf_ctrl_pkg::reg_addr_t              rsv_addr,
  output logic                                rsv_ready,
  input  rf_ctrl_pkg::reg_addr_t              chk_rs1,
  input  rf_ctrl_pkg::reg_addr_t              chk_rs2,
  output logic                                stall,
  output logic                                RegWrite,
  output rf_ctrl_pkg::reg_addr_t              WriteRegister,
  output logic [XLEN-1:0]                     WriteData,
  output logic [rf_ctrl_pkg::NUM_REGS-1:0]    busy
);

  import rf_ctrl_pkg::*;

  logic [N_REQ-1:0]    hold_valid_reg;
  reg_addr_t           hold_addr_reg [N_REQ];
  logic [XLEN-1:0]     hold_data_reg [N_REQ];

  logic [N_REQ-1:0]    arb_req;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    ready;

  logic                gnt_any;
  reg_addr_t           gnt_addr;
  logic [XLEN-1:0]     gnt_data;

  logic                regwrite_reg;
  reg_addr_t           wreg_reg;
  logic [XLEN-1:0]     wdata_reg;

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic                rsv_set;

  // x0 holds never compete for the port; they simply drain.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign arb_req[gi] = hold_valid_reg[gi] && (hold_addr_reg[gi] != '0);
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .en    (gnt_any),
    .gnt   (grant)
  );

  assign ready        = ~hold_valid_reg | grant;
  assign wb.req_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_reg <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        hold_addr_reg[i] <= '0;
        hold_data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (wb.req_valid[i] && ready[i]) begin
          hold_valid_reg[i] <= 1'b1;
          hold_addr_reg[i]  <= wb.req_addr[i];
          hold_data_reg[i]  <= wb.req_data[i];
        end else if (grant[i] || !arb_req[i]) begin
          hold_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    gnt_any  = |grant;
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_addr = hold_addr_reg[i];
        gnt_data = hold_data_reg[i];
      end
    end
  end

  // Address/data only move on a grant so the bank sees a stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_reg <= 1'b0;
      wreg_reg     <= '0;
      wdata_reg    <= '0;
    end else begin
      regwrite_reg <= gnt_any;
      if (gnt_any) begin
        wreg_reg  <= gnt_addr;
        wdata_reg <= gnt_data;
      end
    end
  end

  assign RegWrite      = regwrite_reg;
  assign WriteRegister = wreg_reg;
  assign WriteData     = wdata_reg;

  assign rsv_ready = !busy_reg[rsv_addr];
  assign rsv_set   = rsv_valid && rsv_ready && (rsv_addr != '0);

  // Set is applied after clear so a same-edge reservation survives the write.
  always_comb begin
    busy_next = busy_reg;
    if (gnt_any) begin
      busy_next[gnt_addr] = 1'b0;
    end
    if (rsv_set) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy  = busy_reg;
  assign stall = busy_reg[chk_rs1] || busy_reg[chk_rs2];

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Self-checking bench for rf_write_ctrl: scoreboard of expected write-port pulses plus per-scenario checks.
module tb_rf_write_ctrl;
  import rf_ctrl_pkg::*;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rsv_valid, rsv_ready, stall, RegWrite;
  reg_addr_t   rsv_addr, chk_rs1, chk_rs2, WriteRegister;
  logic [31:0] WriteData, busy;

  int tests = 0;
  int fails = 0;
  wb_req_t exp_q[$];

  rf_write_ctrl_if #(.N_REQ(N), .DW(32)) wb_if ();

  rf_write_ctrl #(.N_REQ(N), .XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb            (wb_if),
    .rsv_valid     (rsv_valid),
    .rsv_addr      (rsv_addr),
    .rsv_ready     (rsv_ready),
    .chk_rs1       (chk_rs1),
    .chk_rs2       (chk_rs2),
    .stall         (stall),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Every write-port pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wb_req_t e;
    if (rst_n && RegWrite) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got write r%0d=%h, required none", WriteRegister, WriteData);
      end else begin
        e = exp_q.pop_front();
        if (WriteRegister !== e.addr || WriteData !== e.data) begin
          fails++;
          $display("FAIL wb_order: got r%0d=%h, required r%0d=%h", WriteRegister, WriteData, e.addr, e.data);
        end else begin
          $display("[TB] write r%0d=%h ok", WriteRegister, WriteData);
        end
      end
    end
  end

  task automatic push(input reg_addr_t a, input logic [31:0] d);
    wb_req_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain_check(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    wb_if.req_valid = '0;
    wb_if.req_addr  = '0;
    wb_if.req_data  = '0;
    rsv_valid = 1'b1; rsv_addr = 5'd3; chk_rs1 = 5'd3; chk_rs2 = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0) begin
      fails++; $display("FAIL reset_port: got %b/%0d/%h, required 0/0/0", RegWrite, WriteRegister, WriteData);
    end
    tests++;
    if (busy !== 32'd0 || stall !== 1'b0 || wb_if.req_ready !== 2'b11) begin
      fails++; $display("FAIL reset_state: got busy=%h stall=%b ready=%b, required 0/0/11", busy, stall, wb_if.req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rsv_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || wb_if.req_ready !== 2'b11) begin
      fails++; $display("FAIL reset_after: got stall=%b ready=%b, required 0/11", stall, wb_if.req_ready);
    end
    $display("[TB] reset checked");
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    wb_if.req_valid = 2'b11;
    wb_if.req_addr[0] = 5'd3; wb_if.req_data[0] = 32'h11;
    wb_if.req_addr[1] = 5'd4; wb_if.req_data[1] = 32'h22;
    push(5'd3, 32'h11); push(5'd4, 32'h22);
    @(posedge clk); #1;
    wb_if.req_valid = 2'b01; wb_if.req_addr[0] = 5'd5; wb_if.req_data[0] = 32'h33;
    push(5'd5, 32'h33);
    @(negedge clk);
    tests++;
    if (wb_if.req_ready !== 2'b01 || RegWrite !== 1'b0) begin
      fails++; $display("FAIL cont_ready: got ready=%b wr=%b, required 01/0", wb_if.req_ready, RegWrite);
    end
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (RegWrite !== 1'b1) begin
        fails++; $display("FAIL cont_b2b: got RegWrite=%b in slot %0d, required 1", RegWrite, k);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd5) begin
      fails++; $display("FAIL cont_idle: got %b/r%0d, required 0/r5", RegWrite, WriteRegister);
    end
    // Last winner was requester 0, so a fresh pair starts with requester 1.
    @(posedge clk); #1;
    wb_if.req_valid = 2'b11;
    wb_if.req_addr[0] = 5'd10; wb_if.req_data[0] = 32'hA;
    wb_if.req_addr[1] = 5'd11; wb_if.req_data[1] = 32'hB;
    push(5'd11, 32'hB); push(5'd10, 32'hA);
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00;
    repeat (3) @(posedge clk); #1;
    drain_check("cont");
  endtask

  task automatic test_x0_discard();
    wb_if.req_valid = 2'b10;
    wb_if.req_addr[1] = 5'd0; wb_if.req_data[1] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (wb_if.req_ready[1] !== 1'b0 || RegWrite !== 1'b0) begin
      fails++; $display("FAIL x0_hold: got ready1=%b wr=%b, required 0/0", wb_if.req_ready[1], RegWrite);
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if (wb_if.req_ready[1] !== 1'b1 || RegWrite !== 1'b0) begin
      fails++; $display("FAIL x0_drop: got ready1=%b wr=%b, required 1/0", wb_if.req_ready[1], RegWrite);
    end
    // Pointer must still favour requester 1.
    @(posedge clk); #1;
    wb_if.req_valid = 2'b11;
    wb_if.req_addr[0] = 5'd12; wb_if.req_data[0] = 32'hC;
    wb_if.req_addr[1] = 5'd13; wb_if.req_data[1] = 32'hD;
    push(5'd13, 32'hD); push(5'd12, 32'hC);
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00;
    repeat (3) @(posedge clk); #1;
    drain_check("x0");
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1; rsv_addr = 5'd7; chk_rs1 = 5'd7; chk_rs2 = 5'd0;
    @(negedge clk);
    tests++;
    if (rsv_ready !== 1'b1 || stall !== 1'b0) begin
      fails++; $display("FAIL sb_pre: got rsv_ready=%b stall=%b, required 1/0", rsv_ready, stall);
    end
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 32'h80 || stall !== 1'b1 || rsv_ready !== 1'b0) begin
      fails++; $display("FAIL sb_set: got busy=%h stall=%b rsv_ready=%b, required 80/1/0", busy, stall, rsv_ready);
    end
    @(posedge clk); #1;
    chk_rs1 = 5'd0; chk_rs2 = 5'd7; rsv_valid = 1'b1; rsv_addr = 5'd0;
    @(negedge clk);
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL sb_rs2: got stall=%b, required 1", stall);
    end
    @(posedge clk); #1;
    rsv_valid = 1'b0; rsv_addr = 5'd7;
    @(negedge clk);
    tests++;
    if (busy !== 32'h80) begin
      fails++; $display("FAIL sb_x0rsv: got busy=%h, required 80", busy);
    end
    @(posedge clk); #1;
    wb_if.req_valid = 2'b01; wb_if.req_addr[0] = 5'd7; wb_if.req_data[0] = 32'h77;
    push(5'd7, 32'h77);
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00;
    @(posedge clk); @(negedge clk);
    tests++;
    if (RegWrite !== 1'b1 || busy !== 32'd0 || stall !== 1'b0 || rsv_ready !== 1'b1) begin
      fails++; $display("FAIL sb_clear: got wr=%b busy=%h stall=%b rsv_ready=%b, required 1/0/0/1", RegWrite, busy, stall, rsv_ready);
    end
    @(posedge clk); #1;
    chk_rs2 = 5'd0;
    drain_check("sb");
  endtask

  task automatic test_same_edge();
    wb_if.req_valid = 2'b01; wb_if.req_addr[0] = 5'd9; wb_if.req_data[0] = 32'h99;
    push(5'd9, 32'h99);
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00; rsv_valid = 1'b1; rsv_addr = 5'd9;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (RegWrite !== 1'b1 || busy[9] !== 1'b1) begin
      fails++; $display("FAIL same_edge: got wr=%b busy9=%b, required 1/1", RegWrite, busy[9]);
    end
    // Two holds to the same register: both land, busy clears on the first.
    @(posedge clk); #1;
    wb_if.req_valid = 2'b11;
    wb_if.req_addr[0] = 5'd9; wb_if.req_data[0] = 32'hA1;
    wb_if.req_addr[1] = 5'd9; wb_if.req_data[1] = 32'hA2;
    push(5'd9, 32'hA2); push(5'd9, 32'hA1);
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00;
    @(posedge clk); @(negedge clk);
    tests++;
    if (RegWrite !== 1'b1 || WriteData !== 32'hA2 || busy[9] !== 1'b0) begin
      fails++; $display("FAIL same_addr: got wr=%b data=%h busy9=%b, required 1/a2/0", RegWrite, WriteData, busy[9]);
    end
    repeat (2) @(posedge clk); #1;
    drain_check("same");
  endtask

  task automatic test_reset_midop();
    rsv_valid = 1'b1; rsv_addr = 5'd15;
    wb_if.req_valid = 2'b11;
    wb_if.req_addr[0] = 5'd16; wb_if.req_data[0] = 32'h16;
    wb_if.req_addr[1] = 5'd17; wb_if.req_data[1] = 32'h17;
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00; rsv_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (RegWrite !== 1'b0 || busy !== 32'd0 || wb_if.req_ready !== 2'b11 || WriteRegister !== 5'd0 || WriteData !== 32'd0) begin
      fails++; $display("FAIL rst_mid: got wr=%b busy=%h ready=%b r%0d=%h, required 0/0/11/r0=0", RegWrite, busy, wb_if.req_ready, WriteRegister, WriteData);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (RegWrite !== 1'b0) begin
        fails++; $display("FAIL rst_ghost: got RegWrite=%b at cycle %0d, required 0", RegWrite, k);
      end
    end
    // Priority restarts at requester 0.
    @(posedge clk); #1;
    wb_if.req_valid = 2'b11;
    wb_if.req_addr[0] = 5'd21; wb_if.req_data[0] = 32'h21;
    wb_if.req_addr[1] = 5'd22; wb_if.req_data[1] = 32'h22;
    push(5'd21, 32'h21); push(5'd22, 32'h22);
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00;
    repeat (3) @(posedge clk); #1;
    drain_check("rst");
  endtask

  task automatic test_single_write();
    wb_if.req_valid = 2'b01; wb_if.req_addr[0] = 5'd5; wb_if.req_data[0] = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    @(posedge clk); #1;
    wb_if.req_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (RegWrite !== 1'b0) begin
      fails++; $display("FAIL single_early: got RegWrite=%b one cycle after accept, required 0", RegWrite);
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single_write: got %b/r%0d=%h, required 1/r5=deadbeef", RegWrite, WriteRegister, WriteData);
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if (RegWrite !== 1'b0 || WriteData !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single_pulse: got %b/%h, required 0/deadbeef", RegWrite, WriteData);
    end
    @(posedge clk); #1;
    drain_check("single");
  endtask

  initial begin
    test_reset();
    test_contention();
    test_x0_discard();
    test_scoreboard();
    test_same_edge();
    test_reset_midop();
    test_single_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
